wb_mem_arbiter: RTL and testbench
=================================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL take parameter AW, default 32, address width.
REQ-002 SHALL take parameter DW, default 32, data width.
REQ-003 SHALL take parameter TIMEOUT, default 255, stalled-strobe cycles before bus error (1..255).
REQ-004 SHALL take parameter PRIO_D, default 1, tie-break mode: 1 = data master wins from reset, 0 = instruction master wins from reset.
REQ-005 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports mN_cyc_i / mN_stb_i / mN_we_i  in  1 each  master N cycle, strobe, write (N=0 instruction bus, N=1 data bus).
REQ-008 SHALL have ports mN_adr_i  in  AW, mN_dat_i  in  DW, mN_sel_i  in  DW/8  master N address, write data, byte selects.
REQ-009 SHALL have ports mN_dat_o  out  DW, mN_ack_o  out  1, mN_err_o  out  1  master N read data, acknowledge, error.
REQ-010 SHALL have ports s_cyc_o / s_stb_o / s_we_o  out  1 each, s_adr_o  out  AW, s_dat_o  out  DW, s_sel_o  out  DW/8  to memory slave.
REQ-011 SHALL have ports s_dat_i  in  DW, s_ack_i  in  1, s_err_i  in  1  from memory slave.
REQ-012 SHALL have port grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0, OWN1; state and last-served pointer are registers.
REQ-014 IDLE: if exactly one mN_cyc_i high, SHALL enter OWNN next edge; if both high, SHALL grant the master not served last; tie before any grant since reset resolved by PRIO_D.
REQ-015 Grant latency SHALL be one cycle: cyc seen in IDLE at edge n, grant_o and s_cyc_o valid after edge n+1.
REQ-016 OWNN SHALL hold while mN_cyc_i high (bursts of multiple strobes allowed, no preemption); when mN_cyc_i low, SHALL return to IDLE next edge and set last-served = N.
REQ-017 Cycle after OWN exit SHALL be IDLE (one dead cycle) even if the other master is waiting.
REQ-018 In OWNN, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o SHALL combinationally follow master N; in IDLE all SHALL be 0.
REQ-019 s_dat_i SHALL drive both mN_dat_o; mN_ack_o = s_ack_i & mN_stb_i & ownN; mN_err_o = (s_err_i | tmo) & mN_stb_i & ownN; non-owner ack/err SHALL be 0.
REQ-020 Timeout counter (8 bit) SHALL increment each cycle s_stb_o=1 and s_ack_i=0 and s_err_i=0, clear on ack, err, IDLE, or tmo.
REQ-021 tmo SHALL assert for exactly one cycle when counter equals TIMEOUT; counter clears next edge; grant retained.
REQ-022 s_ack_i and s_err_i both high SHALL be reported as err only (ack suppressed).
REQ-023 Slave ack/err in IDLE SHALL be ignored (no master output asserts).
REQ-024 Master dropping cyc while its stb awaits ack SHALL release grant normally; late ack SHALL be ignored per REQ-023.

Reset
REQ-025 reset high at an edge SHALL force IDLE, last-served pointer per PRIO_D (as if the other master served last), timeout counter 0, regardless of transaction in flight.
REQ-026 During and after reset, grant_o = 00, all s_* outputs 0, all mN_ack_o/mN_err_o 0; mN_dat_o = s_dat_i.

Verification
REQ-027 Reset, PRIO_D=1, m0_cyc_i and m1_cyc_i rise same cycle -> grant_o=10 after one edge, s_adr_o = m1_adr_i.
REQ-028 Both masters continuously requesting, each doing one strobe then dropping cyc on ack -> grants alternate 01/10 with one IDLE cycle between, no master served twice in a row.
REQ-029 m0 burst of 4 strobes, slave acks each, m1 requesting throughout -> grant_o stays 01 for all 4 acks, m1_ack_o never asserts, then IDLE, then 10.
REQ-030 TIMEOUT=4, m1 strobes, s_ack_i held 0 -> m1_err_o pulses high exactly once on the 5th stalled cycle, m1_ack_o stays 0, grant stays 10.
REQ-031 reset asserted mid-burst during OWN0 -> next cycle grant_o=00, s_cyc_o=0; s_ack_i pulsed afterwards -> m0_ack_o stays 0.
REQ-032 s_ack_i and s_err_i high together for owner m0 with stb -> m0_err_o=1, m0_ack_o=0.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master Wishbone arbiter in front of one memory slave
// Alternating-priority grant, whole-cycle ownership, stalled-strobe timeout to bus error.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int PRIO_D  = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       own0, own1, tmo, err_eff, ack_eff;

  // Outputs are gated by reset so the bus is quiet even before the first edge.
  assign own0 = (state_q == OWN0) && !reset;
  assign own1 = (state_q == OWN1) && !reset;

  assign tmo     = (own0 || own1) && (cnt_q == TMO_LIM);
  assign err_eff = s_err_i || tmo;
  assign ack_eff = s_ack_i && !err_eff;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!(own0 || own1) || s_ack_i || s_err_i || tmo) cnt_d = 8'd0;
    else if (s_stb_o)                                 cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= (PRIO_D == 0);
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = {own1, own0};

  assign s_cyc_o = (own0 && m0_cyc_i) || (own1 && m1_cyc_i);
  assign s_stb_o = (own0 && m0_stb_i) || (own1 && m1_stb_i);
  assign s_we_o  = (own0 && m0_we_i)  || (own1 && m1_we_i);
  assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : '0);
  assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : '0);
  assign s_sel_o = own0 ? m0_sel_i : (own1 ? m1_sel_i : '0);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack_eff && m0_stb_i && own0;
  assign m1_ack_o = ack_eff && m1_stb_i && own1;
  assign m0_err_o = err_eff && m0_stb_i && own0;
  assign m1_err_o = err_eff && m1_stb_i && own1;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - self-checking bench for wb_mem_arbiter
// Cycle vector table plus a datapath sequence, checked through an expectation queue.
module tb_wb_mem_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, m0_dat_o, m1_dat_o;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [31:0] s_adr, s_dat, s_dat_i;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .PRIO_D(1)) dut (
    .clock(clk), .reset(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat), .s_sel_o(s_sel), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .s_err_i(s_err), .grant_o(grant)
  );

  // in  = {rst, c0, s0, c1, s1, ack, err}; out = {a0, e0, a1, e1, s_cyc}
  typedef struct packed {
    logic [6:0] in;
    logic [1:0] g;
    logic [4:0] out;
  } vec_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdat;
  } dexp_t;

  vec_t  tbl [32];
  vec_t  exp_q [$];
  dexp_t dexp_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    logic [31:0] eadr;
    @(posedge clk);
    #1;
    {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} = v.in;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    eadr = (e.g == 2'b01) ? A0 : ((e.g == 2'b10) ? A1 : 32'h0);
    check($sformatf("row%0d grant", idx), 32'(grant),  32'(e.g));
    check($sformatf("row%0d m0_ack", idx), 32'(m0_ack), 32'(e.out[4]));
    check($sformatf("row%0d m0_err", idx), 32'(m0_err), 32'(e.out[3]));
    check($sformatf("row%0d m1_ack", idx), 32'(m1_ack), 32'(e.out[2]));
    check($sformatf("row%0d m1_err", idx), 32'(m1_err), 32'(e.out[1]));
    check($sformatf("row%0d s_cyc", idx),  32'(s_cyc),  32'(e.out[0]));
    check($sformatf("row%0d s_adr", idx),  s_adr,       eadr);
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb} = '0;
    m1_we = 1'b1;
    m0_adr = A0; m1_adr = A1;
    m0_dat = 32'h1111_1111; m1_dat = 32'h2222_2222;
    m0_sel = 4'hF; m1_sel = 4'h3;
    s_dat_i = 32'hCAFE_0000; s_ack = 1'b0; s_err = 1'b0;

    tbl[0]  = {7'b1000000, 2'b00, 5'b00000};
    tbl[1]  = {7'b1000000, 2'b00, 5'b00000};
    tbl[2]  = {7'b0111100, 2'b00, 5'b00000}; // simultaneous request, data master wins
    tbl[3]  = {7'b0111110, 2'b10, 5'b00101};
    tbl[4]  = {7'b0110000, 2'b10, 5'b00000};
    tbl[5]  = {7'b0111100, 2'b00, 5'b00000};
    tbl[6]  = {7'b0111110, 2'b01, 5'b10001};
    tbl[7]  = {7'b0001100, 2'b01, 5'b00000};
    tbl[8]  = {7'b0111100, 2'b00, 5'b00000};
    tbl[9]  = {7'b0111110, 2'b10, 5'b00101};
    tbl[10] = {7'b0110000, 2'b10, 5'b00000};
    tbl[11] = {7'b0111100, 2'b00, 5'b00000};
    tbl[12] = {7'b0111110, 2'b01, 5'b10001}; // m0 burst, m1 waiting
    tbl[13] = {7'b0101100, 2'b01, 5'b00001};
    tbl[14] = {7'b0111110, 2'b01, 5'b10001};
    tbl[15] = {7'b0111110, 2'b01, 5'b10001};
    tbl[16] = {7'b0111110, 2'b01, 5'b10001};
    tbl[17] = {7'b0001110, 2'b01, 5'b00000};
    tbl[18] = {7'b0001110, 2'b00, 5'b00000};
    tbl[19] = {7'b0001100, 2'b10, 5'b00001}; // m1 stalls into timeout
    tbl[20] = {7'b0001100, 2'b10, 5'b00001};
    tbl[21] = {7'b0001100, 2'b10, 5'b00001};
    tbl[22] = {7'b0001100, 2'b10, 5'b00001};
    tbl[23] = {7'b0001100, 2'b10, 5'b00011};
    tbl[24] = {7'b0001100, 2'b10, 5'b00001};
    tbl[25] = {7'b0000000, 2'b10, 5'b00000};
    tbl[26] = {7'b0110000, 2'b00, 5'b00000};
    tbl[27] = {7'b0110011, 2'b01, 5'b01001}; // ack+err reported as err
    tbl[28] = {7'b1110000, 2'b00, 5'b00000}; // reset mid-ownership
    tbl[29] = {7'b0110010, 2'b00, 5'b00000};
    tbl[30] = {7'b0000000, 2'b01, 5'b00000};
    tbl[31] = {7'b0000000, 2'b00, 5'b00000};

    for (int i = 0; i < 32; i++) apply(tbl[i], i);

    for (int k = 0; k < 4; k++) begin
      dexp_t d;
      @(posedge clk);
      #1;
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom);
      m1_we = 1'($urandom); m0_adr = $urandom; s_dat_i = $urandom;
      m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
      d = {m1_adr, m1_dat, m1_sel, m1_we, s_dat_i};
      dexp_q.push_back(d);
      @(negedge clk);
      check($sformatf("dp%0d idle grant", k), 32'(grant), 32'h0);
      @(posedge clk);
      #1;
      s_ack = 1'b1;
      @(negedge clk);
      d = dexp_q.pop_front();
      check($sformatf("dp%0d s_adr", k), s_adr, d.adr);
      check($sformatf("dp%0d s_dat", k), s_dat, d.dat);
      check($sformatf("dp%0d s_sel", k), 32'(s_sel), 32'(d.sel));
      check($sformatf("dp%0d s_we", k), 32'(s_we), 32'(d.we));
      check($sformatf("dp%0d m0_dat", k), m0_dat_o, d.rdat);
      check($sformatf("dp%0d m1_dat", k), m1_dat_o, d.rdat);
      check($sformatf("dp%0d m1_ack", k), 32'(m1_ack), 32'h1);
      @(posedge clk);
      #1;
      m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    end

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
